// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces two raw coin sensors and issues one Coin/Reject pulse per coin.
// Optional saturating acceptance tallies are enabled with `define COIN_TALLY_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TALLY_W         = 8
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                COIN50_RAW,
    input  logic                COIN100_RAW,
    input  logic                HOLD,
    output logic [1:0]          Coin,
    output logic                Reject,
    output logic                Busy
`ifdef COIN_TALLY_EN
    ,
    output logic [TALLY_W-1:0]  Tally50,
    output logic [TALLY_W-1:0]  Tally100
`endif
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit                ONE_CYCLE  = (DEBOUNCE_CYCLES == 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || TALLY_W < 1) begin : g_bad_param
            $error("coin_acceptor: DEBOUNCE_CYCLES and TALLY_W must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_EMIT,
        S_REJECT,
        S_RELEASE
    } state_t;

    // Bit 0 carries the 50 sensor, bit 1 the 100 sensor.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic             s50;
    logic             s100;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             coin_sel_q;   // 0 = 50 coin, 1 = 100 coin
    logic [1:0]       coin_q;
    logic             reject_q;
    logic             busy_q;
    logic             own_in;
    logic             other_in;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {COIN100_RAW, COIN50_RAW};
            sync_q <= meta_q;
        end
    end

    assign s50      = sync_q[0];
    assign s100     = sync_q[1];
    assign own_in   = coin_sel_q ? s100 : s50;
    assign other_in = coin_sel_q ? s50  : s100;
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            coin_sel_q <= 1'b0;
            coin_q     <= 2'b00;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (s50 && s100) begin
                        state_q <= S_REJECT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (s50 ^ s100) begin
                        coin_sel_q <= s100;
                        busy_q     <= 1'b1;
                        // The first stable sample already counts towards qualification.
                        if (ONE_CYCLE) begin
                            state_q <= S_EMIT;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_DEBOUNCE;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    // A second coin showing up wins over the first one vanishing: the slot is ambiguous.
                    if (other_in) begin
                        state_q <= S_REJECT;
                        cnt_q   <= '0;
                    end else if (!own_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_d == CNT_TARGET) begin
                        state_q <= S_EMIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_EMIT: begin
                    if (HOLD) begin
                        reject_q <= 1'b1;
                    end else begin
                        coin_q <= coin_sel_q ? 2'b10 : 2'b01;
                    end
                    state_q <= S_RELEASE;
                    cnt_q   <= '0;
                end
                S_REJECT: begin
                    reject_q <= 1'b1;
                    state_q  <= S_RELEASE;
                    cnt_q    <= '0;
                end
                S_RELEASE: begin
                    if (s50 || s100) begin
                        cnt_q <= '0;
                    end else if (cnt_d == CNT_TARGET) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Coin   = coin_q;
    assign Reject = reject_q;
    assign Busy   = busy_q;

`ifdef COIN_TALLY_EN
    logic [TALLY_W-1:0] tally50_q;
    logic [TALLY_W-1:0] tally100_q;
    logic [TALLY_W-1:0] tally50_d;
    logic [TALLY_W-1:0] tally100_d;
    logic               accept_w;

    // Counts only coins actually handed downstream; held or rejected coins are not tallied.
    assign accept_w = (state_q == S_EMIT) && !HOLD;

    always_comb begin
        tally50_d  = tally50_q;
        tally100_d = tally100_q;
        if (accept_w) begin
            if (!coin_sel_q && (tally50_q != '1)) begin
                tally50_d = tally50_q + TALLY_W'(1);
            end
            if (coin_sel_q && (tally100_q != '1)) begin
                tally100_d = tally100_q + TALLY_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            tally50_q  <= '0;
            tally100_q <= '0;
        end else begin
            tally50_q  <= tally50_d;
            tally100_q <= tally100_d;
        end
    end

    assign Tally50  = tally50_q;
    assign Tally100 = tally100_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus randomized sensor traffic checked every cycle against a coin-episode model.
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int D    = 4;
    localparam int TW   = 8;
    localparam int TMAX = (1 << TW) - 1;

    logic       CLK         = 1'b0;
    logic       nRESET      = 1'b0;
    logic       COIN50_RAW  = 1'b0;
    logic       COIN100_RAW = 1'b0;
    logic       HOLD        = 1'b0;
    logic [1:0] Coin;
    logic       Reject;
    logic       Busy;
`ifdef COIN_TALLY_EN
    logic [TW-1:0] Tally50;
    logic [TW-1:0] Tally100;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .TALLY_W(TW)) dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .COIN50_RAW  (COIN50_RAW),
        .COIN100_RAW (COIN100_RAW),
        .HOLD        (HOLD),
        .Coin        (Coin),
        .Reject      (Reject),
        .Busy        (Busy)
`ifdef COIN_TALLY_EN
        ,
        .Tally50     (Tally50),
        .Tally100    (Tally100)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Observation counters (DUT behaviour seen at each falling edge)
    int c50 = 0, c100 = 0, crej = 0;
    int first_coin = -1;
    int busy_fall  = -1;
    bit busy_prev  = 1'b0;

    // Coin-episode model
    bit [1:0] h50, h100;        // raw samples: [0] one edge ago, [1] two edges ago
    int m_kind  = 0;            // coin being qualified: 0 none, 1 = 50, 2 = 100
    int m_run   = 0;            // consecutive clean samples of that coin
    int m_quiet = 0;            // consecutive empty-slot samples after a verdict
    bit m_verdict = 0;          // a verdict is due on the next edge
    bit m_accept  = 0;          // verdict is "accept" (subject to HOLD) rather than "reject"
    bit m_drain   = 0;          // waiting for the slot to empty
    bit m_busy    = 0;
    int m_coin    = 0;
    bit m_rej     = 0;
    int m_t50     = 0;
    int m_t100    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        h50 = 2'b00; h100 = 2'b00;
        m_kind = 0; m_run = 0; m_quiet = 0;
        m_verdict = 0; m_accept = 0; m_drain = 0; m_busy = 0;
        m_coin = 0; m_rej = 0; m_t50 = 0; m_t100 = 0;
    endtask

    task automatic model_step();
        bit a, b, own, other;
        a = h50[1];
        b = h100[1];
        h50  = {h50[0],  COIN50_RAW};
        h100 = {h100[0], COIN100_RAW};
        m_coin = 0;
        m_rej  = 0;
        if (m_verdict) begin
            m_verdict = 0;
            m_drain   = 1;
            m_quiet   = 0;
            if (m_accept && !HOLD) begin
                m_coin = m_kind;
                if (m_kind == 1 && m_t50 < TMAX)  m_t50++;
                if (m_kind == 2 && m_t100 < TMAX) m_t100++;
            end else begin
                m_rej = 1;
            end
            m_kind = 0;
        end else if (m_drain) begin
            m_quiet = (a || b) ? 0 : m_quiet + 1;
            if (m_quiet == D) begin
                m_drain = 0;
                m_busy  = 0;
            end
        end else if (m_kind == 0) begin
            if (a && b) begin
                m_verdict = 1; m_accept = 0; m_busy = 1;
            end else if (a || b) begin
                m_kind = a ? 1 : 2;
                m_run  = 1;
                m_busy = 1;
                if (m_run >= D) begin m_verdict = 1; m_accept = 1; end
            end
        end else begin
            own   = (m_kind == 1) ? a : b;
            other = (m_kind == 1) ? b : a;
            if (other) begin
                m_verdict = 1; m_accept = 0;
            end else if (!own) begin
                m_kind = 0; m_busy = 0;
            end else begin
                m_run++;
                if (m_run == D) begin m_verdict = 1; m_accept = 1; end
            end
        end
    endtask

    initial forever begin
        @(posedge CLK or negedge nRESET);
        if (!nRESET) model_reset();
        else         model_step();
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Per-cycle comparison and observation
    initial forever begin
        @(negedge CLK);
        check("coin",   Coin,   m_coin);
        check("reject", Reject, m_rej);
        check("busy",   Busy,   m_busy);
`ifdef COIN_TALLY_EN
        check("tally50",  Tally50,  m_t50);
        check("tally100", Tally100, m_t100);
`endif
        if (Coin == 2'b01) begin
            c50++;
            if (first_coin < 0) first_coin = cyc;
        end
        if (Coin == 2'b10) c100++;
        if (Reject) crej++;
        if (busy_prev && !Busy) busy_fall = cyc;
        busy_prev = Busy;
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int k, f, j, b50, b100, brej;

        nRESET = 1'b0;
        repeat (3) step();
        nRESET = 1'b1;
        repeat (3) step();
        check("reset_coin",   Coin,   0);
        check("reset_reject", Reject, 0);
        check("reset_busy",   Busy,   0);

        // 1: clean 50 coin
        b50 = c50; brej = crej; first_coin = -1;
        COIN50_RAW = 1'b1; k = cyc + 1;
        repeat (12) step();
        COIN50_RAW = 1'b0; f = cyc + 1;
        repeat (12) step();
        $display("T1 clean 50: pulses=%0d latency=%0d busy_fall=%0d", c50 - b50, first_coin - k, busy_fall - f);
        check("t1_coin50_count", c50 - b50, 1);
        check("t1_reject_count", crej - brej, 0);
        check("t1_latency",      first_coin - k, D + 2);
        check("t1_busy_release", busy_fall - f, D + 1);

        // 2: 100 glitch
        b100 = c100; brej = crej;
        COIN100_RAW = 1'b1;
        repeat (2) step();
        COIN100_RAW = 1'b0;
        repeat (12) step();
        $display("T2 glitch 100: coin=%0d reject=%0d busy=%0d", c100 - b100, crej - brej, Busy);
        check("t2_coin100_count", c100 - b100, 0);
        check("t2_reject_count",  crej - brej, 0);
        check("t2_busy_low",      Busy, 0);

        // 3: both sensors together
        b50 = c50; b100 = c100; brej = crej;
        COIN50_RAW = 1'b1; COIN100_RAW = 1'b1;
        repeat (10) step();
        COIN50_RAW = 1'b0; COIN100_RAW = 1'b0;
        repeat (14) step();
        $display("T3 both: coins=%0d reject=%0d", (c50 - b50) + (c100 - b100), crej - brej);
        check("t3_reject_count", crej - brej, 1);
        check("t3_coin_count",   (c50 - b50) + (c100 - b100), 0);

        // 4: 100 coin while downstream holds
        b100 = c100; brej = crej;
        HOLD = 1'b1; COIN100_RAW = 1'b1;
        repeat (12) step();
        COIN100_RAW = 1'b0;
        repeat (12) step();
        HOLD = 1'b0;
        $display("T4 held 100: coin=%0d reject=%0d", c100 - b100, crej - brej);
        check("t4_reject_count",  crej - brej, 1);
        check("t4_coin100_count", c100 - b100, 0);
`ifdef COIN_TALLY_EN
        check("t4_tally100", Tally100, 0);
`endif

        // 5: bouncing 50 coin 1-0-1-1-1-1
        b50 = c50; first_coin = -1;
        COIN50_RAW = 1'b1; step();
        COIN50_RAW = 1'b0; step();
        COIN50_RAW = 1'b1; j = cyc + 1;
        repeat (7) step();
        COIN50_RAW = 1'b0;
        repeat (12) step();
        $display("T5 bounce 50: pulses=%0d latency_from_stable=%0d", c50 - b50, first_coin - j);
        check("t5_coin50_count", c50 - b50, 1);
        check("t5_latency",      first_coin - j, D + 2);

        // 6: reset while debouncing
        b50 = c50; brej = crej;
        COIN50_RAW = 1'b1;
        repeat (4) step();
        nRESET = 1'b0;
        #1;
        check("t6_busy_async",   Busy,   0);
        check("t6_coin_async",   Coin,   0);
        check("t6_reject_async", Reject, 0);
        COIN50_RAW = 1'b0;
        repeat (2) step();
        nRESET = 1'b1;
        repeat (15) step();
        $display("T6 reset mid-debounce: coin=%0d reject=%0d", c50 - b50, crej - brej);
        check("t6_no_stale_coin",   c50 - b50, 0);
        check("t6_no_stale_reject", crej - brej, 0);

`ifdef COIN_TALLY_EN
        b50 = c50;
        for (int i = 0; i < 300; i++) begin
            COIN50_RAW = 1'b1;
            repeat (D + 2) step();
            COIN50_RAW = 1'b0;
            repeat (D + 4) step();
        end
        $display("TALLY 300x50: pulses=%0d Tally50=%0d", c50 - b50, Tally50);
        check("tally_coin50_count", c50 - b50, 300);
        check("tally50_saturated",  Tally50, 255);
`endif

        // Randomized sensor traffic
        for (int seg = 0; seg < 300; seg++) begin
            int pat, len;
            pat = $urandom_range(0, 5);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                case (pat)
                    2:       begin COIN50_RAW = 1'b1; COIN100_RAW = 1'b0; end
                    3:       begin COIN50_RAW = 1'b0; COIN100_RAW = 1'b1; end
                    4:       begin COIN50_RAW = 1'b1; COIN100_RAW = 1'b1; end
                    5:       begin COIN50_RAW = 1'($urandom_range(0, 1)); COIN100_RAW = 1'($urandom_range(0, 1)); end
                    default: begin COIN50_RAW = 1'b0; COIN100_RAW = 1'b0; end
                endcase
                HOLD = ($urandom_range(0, 3) == 0);
                step();
            end
            if ($urandom_range(0, 40) == 0) begin
                nRESET = 1'b0;
                step();
                nRESET = 1'b1;
            end
        end
        COIN50_RAW = 1'b0; COIN100_RAW = 1'b0; HOLD = 1'b0;
        repeat (20) step();
        $display("RANDOM done: coin50=%0d coin100=%0d reject=%0d", c50, c100, crej);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
